// File: rtl/fetch_branch_unit_if.sv
// Fetch front-end bus: instruction memory port, decode-facing instruction queue head,
// execute-stage branch resolution, and status/statistics outputs.
interface fetch_branch_unit_if #(
    parameter int XLEN = 64,
    parameter int CW   = 3
);
    logic [XLEN-1:0] imem_addr;
    logic [31:0]     imem_rdata;
    logic            inst_valid;
    logic            inst_ready;
    logic [31:0]     inst_data;
    logic [XLEN-1:0] inst_pc;
    logic            br_valid;
    logic [2:0]      br_funct3;
    logic [XLEN-1:0] br_rs1;
    logic [XLEN-1:0] br_rs2;
    logic [XLEN-1:0] br_pc;
    logic [XLEN-1:0] br_imm;
    logic            redirect;
    logic            fault;
    logic [CW-1:0]   count;
    logic [31:0]     br_total;
    logic [31:0]     br_taken_total;

    modport master (
        output imem_addr, input imem_rdata,
        output inst_valid, input inst_ready, output inst_data, output inst_pc,
        input br_valid, input br_funct3, input br_rs1, input br_rs2, input br_pc, input br_imm,
        output redirect, output fault, output count, output br_total, output br_taken_total
    );

    modport slave (
        input imem_addr, output imem_rdata,
        input inst_valid, output inst_ready, input inst_data, input inst_pc,
        output br_valid, output br_funct3, output br_rs1, output br_rs2, output br_pc, output br_imm,
        input redirect, input fault, input count, input br_total, input br_taken_total
    );
endinterface

// File: rtl/fetch_branch_unit.sv
// PC owner + instruction queue + branch resolver; fetch-to-head 1 cycle, taken-branch penalty 2 cycles.
// Decode backpressure via inst_ready: queue fills to QDEPTH, then the PC holds until a slot frees.
module fetch_branch_unit #(
    parameter int              XLEN     = 64,
    parameter int              QDEPTH   = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              CW       = $clog2(QDEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    fetch_branch_unit_if.master bus
);
    localparam int AW = $clog2(QDEPTH);

    typedef enum logic {RUN, FAULT} state_t;

    state_t          state, state_nxt;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] q_pc   [QDEPTH];
    logic [31:0]     q_inst [QDEPTH];
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count;
    logic            redirect;
    logic [31:0]     br_total, br_taken_total;

    logic [XLEN-1:0] target;
    logic            cond, br_fire, take, misalign, pop, push;

    always_comb begin
        cond = 1'b0;
        case (bus.br_funct3)
            3'b000:  cond = (bus.br_rs1 == bus.br_rs2);
            3'b001:  cond = (bus.br_rs1 != bus.br_rs2);
            3'b100:  cond = ($signed(bus.br_rs1) <  $signed(bus.br_rs2));
            3'b101:  cond = ($signed(bus.br_rs1) >= $signed(bus.br_rs2));
            3'b110:  cond = (bus.br_rs1 <  bus.br_rs2);
            3'b111:  cond = (bus.br_rs1 >= bus.br_rs2);
            default: cond = 1'b0;
        endcase
    end

    // Immediate is in halfword units; the add wraps at XLEN.
    assign target   = bus.br_pc + (bus.br_imm << 1);
    assign misalign = (target[1:0] != 2'b00);
    assign br_fire  = bus.br_valid && (state == RUN);
    assign take     = br_fire && cond;
    assign pop      = (count != '0) && bus.inst_ready;
    assign push     = (state == RUN) && !take && ((count < CW'(QDEPTH)) || pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= RUN;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state == RUN && take && misalign) state_nxt = FAULT;
    end

    // A flush discards everything, including the entry popped on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc       <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            redirect <= 1'b0;
        end else begin
            redirect <= take && !misalign;
            if (take) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
                if (!misalign) pc <= target;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                    pc     <= pc + XLEN'(4);
                end
                if (pop) rd_ptr <= rd_ptr + AW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            br_total       <= '0;
            br_taken_total <= '0;
        end else begin
            if (br_fire && br_total != '1)    br_total       <= br_total + 32'd1;
            if (take && br_taken_total != '1) br_taken_total <= br_taken_total + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr]   <= pc;
            q_inst[wr_ptr] <= bus.imem_rdata;
        end
    end

    assign bus.imem_addr      = pc;
    assign bus.inst_valid     = (count != '0);
    assign bus.inst_data      = q_inst[rd_ptr];
    assign bus.inst_pc        = q_pc[rd_ptr];
    assign bus.redirect       = redirect;
    assign bus.fault          = (state == FAULT);
    assign bus.count          = count;
    assign bus.br_total       = br_total;
    assign bus.br_taken_total = br_taken_total;
endmodule

// File: tb/tb_fetch_branch_unit.sv
// Randomized bench for fetch_branch_unit: queue-based reference model, scoreboard of delivered instructions.
module tb_fetch_branch_unit;
    localparam int QDEPTH = 4;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
    } ent_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fetch_branch_unit_if #(.XLEN(64), .CW(3)) bus();

    fetch_branch_unit #(.XLEN(64), .QDEPTH(QDEPTH), .RESET_PC(64'h0)) dut (
        .clk(clk), .reset(reset), .bus(bus.master)
    );

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction
    assign bus.imem_rdata = mem_word(bus.imem_addr);

    int n_chk = 0;
    int n_pass = 0;

    ent_t        mq[$];   // model of the instruction queue
    ent_t        sb[$];   // instructions expected to be handed to decode
    logic [63:0] m_pc;
    logic        m_fault, m_redirect;
    logic [31:0] m_total, m_taken;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic br_taken(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b);
        case (f)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return $signed(a) <  $signed(b);
            3'd5: return $signed(a) >= $signed(b);
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        mq.delete();
        sb.delete();
        m_pc = 64'h0;
        m_fault = 1'b0;
        m_redirect = 1'b0;
        m_total = 32'h0;
        m_taken = 32'h0;
    endtask

    // Effect of the coming clock edge, given the inputs now on the bus.
    task automatic model_step();
        logic        tk;
        logic [63:0] tgt;
        ent_t        e;
        tk = 1'b0;
        if (mq.size() != 0 && bus.inst_ready) sb.push_back(mq.pop_front());
        m_redirect = 1'b0;
        if (!m_fault) begin
            if (bus.br_valid) begin
                if (m_total != 32'hFFFF_FFFF) m_total++;
                tk = br_taken(bus.br_funct3, bus.br_rs1, bus.br_rs2);
                if (tk) begin
                    if (m_taken != 32'hFFFF_FFFF) m_taken++;
                    tgt = bus.br_pc + 2 * bus.br_imm;
                    mq.delete();
                    if (tgt[1:0] != 2'b00) m_fault = 1'b1;
                    else begin
                        m_pc = tgt;
                        m_redirect = 1'b1;
                    end
                end
            end
            if (!tk && mq.size() < QDEPTH) begin
                e.pc = m_pc;
                e.inst = mem_word(m_pc);
                mq.push_back(e);
                m_pc = m_pc + 64'd4;
            end
        end
    endtask

    task automatic check_state();
        chk("inst_valid", bus.inst_valid, mq.size() != 0);
        chk("count", bus.count, mq.size());
        chk("imem_addr", bus.imem_addr, m_pc);
        chk("redirect", bus.redirect, m_redirect);
        chk("fault", bus.fault, m_fault);
        chk("br_total", bus.br_total, m_total);
        chk("br_taken_total", bus.br_taken_total, m_taken);
        if (mq.size() != 0) chk("head_pc", bus.inst_pc, mq[0].pc);
    endtask

    // Returns 1 ns after the next rising edge, ready for new input values.
    task automatic cycle();
        @(negedge clk);
        check_state();
        if (!reset) model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    // Monitor: every handshake must match the next scoreboard entry.
    initial begin
        ent_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!reset && bus.inst_valid && bus.inst_ready) begin
                chk("pop_expected", sb.size() != 0, 1'b1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("pop_pc", bus.inst_pc, e.pc);
                    chk("pop_inst", bus.inst_data, e.inst);
                end
            end
        end
    end

    function automatic logic [63:0] pick_op();
        case ($urandom_range(0, 5))
            0: return 64'h0;
            1: return 64'h1;
            2: return 64'hFFFF_FFFF_FFFF_FFFF;
            3: return 64'h8000_0000_0000_0000;
            4: return 64'h7FFF_FFFF_FFFF_FFFF;
            default: return {32'h0, $urandom_range(0, 3)};
        endcase
    endfunction

    task automatic rand_inputs();
        logic signed [63:0] imm;
        bus.inst_ready = ($urandom_range(0, 3) != 0);
        bus.br_valid   = ($urandom_range(0, 7) == 0);
        bus.br_funct3  = 3'($urandom_range(0, 7));
        bus.br_rs1     = pick_op();
        bus.br_rs2     = pick_op();
        bus.br_pc      = {$urandom, $urandom} & ~64'h3;
        imm = 64'($urandom_range(0, 2000)) - 64'sd1000;
        imm = imm & ~64'sd1;
        if ($urandom_range(0, 15) == 0) imm = imm | 64'sd1;
        bus.br_imm = imm;
    endtask

    task automatic set_branch(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b,
                              input logic [63:0] p, input logic [63:0] imm);
        bus.br_valid = 1'b1;
        bus.br_funct3 = f;
        bus.br_rs1 = a;
        bus.br_rs2 = b;
        bus.br_pc = p;
        bus.br_imm = imm;
    endtask

    initial begin
        bus.inst_ready = 1'b0;
        bus.br_valid = 1'b0;
        bus.br_funct3 = 3'd0;
        bus.br_rs1 = '0;
        bus.br_rs2 = '0;
        bus.br_pc = '0;
        bus.br_imm = '0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Streaming with decode always ready.
        bus.inst_ready = 1'b1;
        repeat (12) cycle();

        // Stall: queue fills, PC holds, then drains in order.
        do_reset();
        bus.inst_ready = 1'b0;
        repeat (10) cycle();
        chk("stall_count", bus.count, 3'd4);
        chk("stall_addr", bus.imem_addr, 64'd16);
        bus.inst_ready = 1'b1;
        repeat (10) cycle();

        // Unsigned lt taken (1 < all-ones), signed lt not taken with the same operands.
        set_branch(3'b110, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h40, 64'h8);
        cycle();
        bus.br_valid = 1'b0;
        chk("bltu_redirect", bus.redirect, 1'b1);
        chk("bltu_count", bus.count, 3'd0);
        chk("bltu_addr", bus.imem_addr, 64'h50);
        repeat (3) cycle();
        set_branch(3'b100, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h40, 64'h8);
        cycle();
        bus.br_valid = 1'b0;
        chk("blt_redirect", bus.redirect, 1'b0);
        repeat (3) cycle();

        // Taken branch on a full queue with a pop on the same edge.
        bus.inst_ready = 1'b0;
        repeat (6) cycle();
        bus.inst_ready = 1'b1;
        set_branch(3'b000, 64'd5, 64'd5, 64'h100, 64'h20);
        cycle();
        bus.br_valid = 1'b0;
        chk("flush_count", bus.count, 3'd0);
        chk("flush_addr", bus.imem_addr, 64'h140);
        repeat (4) cycle();

        // Randomized traffic; recover from faults with a reset now and then.
        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            cycle();
            if (m_fault && $urandom_range(0, 15) == 0) begin
                bus.br_valid = 1'b0;
                do_reset();
            end
        end

        // Misaligned target faults; branches are then ignored until reset.
        bus.br_valid = 1'b0;
        do_reset();
        bus.inst_ready = 1'b1;
        repeat (3) cycle();
        set_branch(3'b000, 64'd7, 64'd7, 64'h40, 64'h1);
        cycle();
        chk("fault_set", bus.fault, 1'b1);
        for (int i = 0; i < 8; i++) begin
            rand_inputs();
            bus.br_valid = 1'b1;
            cycle();
        end
        bus.br_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("async_fault", bus.fault, 1'b0);
        chk("async_addr", bus.imem_addr, 64'h0);
        chk("async_count", bus.count, 3'd0);
        model_reset();
        cycle();
        reset = 1'b0;
        repeat (5) cycle();

        bus.inst_ready = 1'b0;
        cycle();
        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/fetch_branch_unit.md
# fetch_branch_unit

Parametrised fetch front end for the RISC-V core: owns the program counter, fetches from instruction memory into a small instruction queue with a valid/ready handshake, and resolves all six RV conditional branches with correct signed/unsigned compares. It replaces the single-cycle PC/adder/branch-mux path and decouples fetch from decode, so a later pipelined datapath can stall without losing instructions. Sits between `Instruction_Memory` and the decode stage; the execute stage feeds branch resolution back.

## Interface
- XLEN, 64, data/address width
- QDEPTH, 4, instruction queue entries (power of two, ≥2)
- RESET_PC, 0, PC value after reset
- CW, $clog2(QDEPTH+1), occupancy width
- clk  in  1  clock, all state on rising edge
- reset  in  1  **one clock; reset is asynchronous and active-high**
- imem_addr  out  XLEN  fetch address (= PC register)
- imem_rdata  in  32  instruction at imem_addr, combinational same cycle
- inst_valid  out  1  queue head valid
- inst_ready  in  1  decode accepts head
- inst_data  out  32  head instruction
- inst_pc  out  XLEN  head PC
- br_valid  in  1  branch resolving this cycle
- br_funct3  in  3  branch type
- br_rs1, br_rs2  in  XLEN  operands
- br_pc  in  XLEN  PC of the branch
- br_imm  in  XLEN  sign-extended immediate (halfword units)
- redirect  out  1  one-cycle pulse: taken branch applied last edge
- fault  out  1  sticky misaligned-target fault
- count  out  CW  queue occupancy
- br_total, br_taken_total  out  32  saturating branch statistics

## Operation
- States: RUN, FAULT. Reset → RUN.
- Branch condition by br_funct3: 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge; 010/011 → not taken, not counted as taken.
- Target = br_pc + (br_imm << 1), XLEN wrap-around, no overflow flag.
- RUN, taken branch, target[1:0]==0: PC ← target, queue flushed (count ← 0), enqueue suppressed this edge, redirect ← 1 next cycle.
- RUN, taken branch, target[1]==1: → FAULT, fault ← 1, PC unchanged, queue flushed.
- FAULT: no enqueue, PC frozen, branches ignored (not counted); queue stays empty; exit only via reset.
- Enqueue (RUN, no taken branch): when count<QDEPTH or a pop occurs the same edge; writes {PC, imem_rdata}; PC ← PC+4.
- Pop: inst_valid & inst_ready. inst_valid = (count!=0).
- Full with simultaneous pop: push and pop both occur, count unchanged.
- Flush and pop same edge: flush wins; popped head still considered consumed by decode.
- Not-taken or illegal funct3: no effect on fetch.
- br_total increments on every br_valid in RUN; br_taken_total on every taken branch (including faulting one); both saturate at 0xFFFF_FFFF.

## Timing
- Reset values: imem_addr=RESET_PC, inst_valid=0, count=0, redirect=0, fault=0, counters=0; inst_data/inst_pc don't-care while inst_valid=0.
- Fetch-to-head latency: instruction at PC p is enqueued at edge N, inst_valid at cycle N+1 if queue was empty.
- Taken branch sampled at edge N: cycle N+1 redirect=1, count=0, imem_addr=target; target enqueued edge N+1, inst_valid cycle N+2. Penalty: 2 cycles of empty head.
- Reset mid-operation: all state returns to reset values immediately (asynchronous), queue contents discarded.
- inst_ready may be asserted without inst_valid; no effect.
- Stall (inst_ready=0): queue fills to QDEPTH, then PC holds; head, inst_data, inst_pc stable until popped.

## Test plan
- Reset then inst_ready=1, sequential memory → inst_pc 0,4,8,… one per cycle from cycle 1, count≤1.
- inst_ready=0 for 10 cycles → count saturates at 4, imem_addr holds at 16; release → PCs 0,4,8,12,16 delivered in order, no loss/duplication.
- br_valid, funct3=110, rs1=1, rs2=0xFFFF_FFFF_FFFF_FFFF, br_pc=0x40, imm=8 → taken, next cycle redirect=1, count=0, imem_addr=0x50; same operands funct3=100 → not taken.
- Taken branch with queue full and inst_ready=1 same edge → flush wins, count=0, head at target two cycles later.
- Branch br_pc=0x40, imm=1 taken (beq, equal) → fault=1, no further inst_valid, br_total frozen; assert reset mid-cycle → fault=0, imem_addr=RESET_PC instantly.
- Counters preloaded near 0xFFFF_FFFF via long run (or QDEPTH=2, XLEN=32 variant) → saturate, no wrap.
